// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: two-flop input synchronizer, programmable bit divider,
// mid-bit sampling FSM and a one-entry valid/ready output buffer.
module uart_rx_core #(
    parameter int unsigned DEFAULT_DIV = 1084,
    parameter int unsigned DIV_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_rx,
    input  logic             cfg_div_we,
    input  logic [DIV_W-1:0] cfg_div_di,
    output logic [DIV_W-1:0] cfg_div_do,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    localparam logic [DIV_W-1:0] DivReset = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DivMin   = DIV_W'(2);
    localparam logic [DIV_W-1:0] One      = DIV_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             cnt_zero;
    logic             deliver;
    logic             bad_stop;

    assign rxs      = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    // Divider register; values below 2 would make the half-bit delay zero.
    always_comb begin
        div_d = div_q;
        if (cfg_div_we) begin
            div_d = (cfg_div_di < DivMin) ? DivMin : cfg_div_di;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_act_d = div_act_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        deliver   = 1'b0;
        bad_stop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    // Latch the divider so mid-frame writes only affect the next frame.
                    state_d   = StStart;
                    div_act_d = div_q;
                    cnt_d     = (div_q >> 1) - One;
                end
            end
            StStart: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = 3'd0;
                        cnt_d   = div_act_q - One;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StData: begin
                if (cnt_zero) begin
                    sr_d  = {rxs, sr_q[7:1]};
                    cnt_d = div_act_q - One;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StStop: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StBreak: begin
                // Hold off until the line is released so a held-low line is not a start.
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output buffer: a simultaneous drain lets a new byte replace the old one.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = bad_stop;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = sr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            div_q     <= DivReset;
            div_act_q <= DivReset;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sr_q      <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], ser_rx};
            div_q     <= div_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign cfg_div_do = div_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: drives 8N1 frames and checks the byte buffer,
// error pulses, divider handling and reset with immediate assertions.
module tb_uart_rx_core;

    logic        clk;
    logic        reset;
    logic        ser_rx;
    logic        cfg_div_we;
    logic [15:0] cfg_div_di;
    logic [15:0] cfg_div_do;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Free-running event counters; tests compare differences across a window.
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         n_busy  = 0;
    logic [7:0] last_data = 8'h00;

    int s_valid, s_ferr, s_ovr, s_busy;

    uart_rx_core #(
        .DEFAULT_DIV(1084),
        .DIV_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_rx    (ser_rx),
        .cfg_div_we(cfg_div_we),
        .cfg_div_di(cfg_div_di),
        .cfg_div_do(cfg_div_do),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                n_valid   = n_valid + 1;
                last_data = rx_data;
            end
            if (frame_err) n_ferr = n_ferr + 1;
            if (overrun) n_ovr = n_ovr + 1;
            if (busy) n_busy = n_busy + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = n_valid;
        s_ferr  = n_ferr;
        s_ovr   = n_ovr;
        s_busy  = n_busy;
    endtask

    task automatic idle(input int n, input logic level);
        ser_rx = level;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_div(input logic [15:0] v);
        cfg_div_we = 1'b1;
        cfg_div_di = v;
        @(posedge clk);
        #1;
        cfg_div_we = 1'b0;
    endtask

    // Drives one frame (or its first ncyc cycles); optionally pulses a divider write.
    task automatic send(input logic [7:0] b, input logic stop_b, input int div,
                        input int ncyc, input int wr_at, input logic [15:0] wr_val);
        int n;
        int bi;
        n = (ncyc > 0) ? ncyc : 10 * div;
        for (int i = 0; i < n; i++) begin
            bi = i / div;
            if (bi == 0) ser_rx = 1'b0;
            else if (bi <= 8) ser_rx = b[bi-1];
            else ser_rx = stop_b;
            cfg_div_we = (i == wr_at);
            if (i == wr_at) cfg_div_di = wr_val;
            @(posedge clk);
            #1;
        end
        cfg_div_we = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        ser_rx     = 1'b1;
        cfg_div_we = 1'b0;
        cfg_div_di = 16'd0;
        rx_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_div", 32'(cfg_div_do), 32'd1084);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({frame_err, overrun}), 32'd0);
        reset = 1'b0;
        idle(5, 1'b1);

        // Single byte, consumer always ready
        write_div(16'd16);
        check("div16", 32'(cfg_div_do), 32'd16);
        rx_ready = 1'b1;
        idle(5, 1'b1);
        snap();
        send(8'h55, 1'b1, 16, 0, -1, 16'd0);
        idle(10, 1'b1);
        check("t1_nvalid", 32'(n_valid - s_valid), 32'd1);
        check("t1_data", 32'(last_data), 32'h55);
        check("t1_ferr", 32'(n_ferr - s_ferr), 32'd0);
        check("t1_ovr", 32'(n_ovr - s_ovr), 32'd0);
        check("t1_busy_cycles", 32'(n_busy - s_busy), 32'd152);
        check("t1_valid_low", 32'(rx_valid), 32'd0);

        // Back-to-back bytes with consumer stalled
        rx_ready = 1'b0;
        snap();
        send(8'hA3, 1'b1, 16, 0, -1, 16'd0);
        send(8'h0F, 1'b1, 16, 0, -1, 16'd0);
        idle(10, 1'b1);
        check("t2_valid", 32'(rx_valid), 32'd1);
        check("t2_data", 32'(rx_data), 32'hA3);
        check("t2_ovr", 32'(n_ovr - s_ovr), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("t2_drained", 32'(rx_valid), 32'd0);

        // Framing error, held-low line, then recovery
        rx_ready = 1'b1;
        snap();
        send(8'h3C, 1'b0, 16, 0, -1, 16'd0);
        idle(40, 1'b0);
        check("t3_break_busy", 32'(busy), 32'd1);
        idle(20, 1'b1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_ferr", 32'(n_ferr - s_ferr), 32'd1);
        check("t3_nvalid", 32'(n_valid - s_valid), 32'd0);
        snap();
        send(8'h81, 1'b1, 16, 0, -1, 16'd0);
        idle(10, 1'b1);
        check("t3_next_nvalid", 32'(n_valid - s_valid), 32'd1);
        check("t3_next_data", 32'(last_data), 32'h81);

        // Short glitch on idle line
        snap();
        idle(5, 1'b0);
        idle(30, 1'b1);
        check("t4_nvalid", 32'(n_valid - s_valid), 32'd0);
        check("t4_ferr", 32'(n_ferr - s_ferr), 32'd0);
        check("t4_busy_cycles", 32'(n_busy - s_busy), 32'd8);
        check("t4_idle", 32'(busy), 32'd0);

        // Divider clamp and mid-frame divider write
        write_div(16'd1);
        check("t5_clamp", 32'(cfg_div_do), 32'd2);
        write_div(16'd16);
        idle(5, 1'b1);
        snap();
        send(8'h5A, 1'b1, 16, 0, 50, 16'd1084);
        idle(10, 1'b1);
        check("t5_nvalid", 32'(n_valid - s_valid), 32'd1);
        check("t5_data16", 32'(last_data), 32'h5A);
        check("t5_div", 32'(cfg_div_do), 32'd1084);
        snap();
        send(8'h0A, 1'b1, 1084, 0, -1, 16'd0);
        idle(20, 1'b1);
        check("t5_nvalid1084", 32'(n_valid - s_valid), 32'd1);
        check("t5_data1084", 32'(last_data), 32'h0A);

        // Reset mid-frame with a byte buffered
        write_div(16'd16);
        rx_ready = 1'b0;
        send(8'h11, 1'b1, 16, 0, -1, 16'd0);
        idle(5, 1'b1);
        check("t6_buffered", 32'(rx_valid), 32'd1);
        send(8'h00, 1'b1, 16, 48, -1, 16'd0);
        check("t6_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_valid", 32'(rx_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_div", 32'(cfg_div_do), 32'd1084);
        check("t6_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        idle(20, 1'b1);
        check("t6_after_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
